// File: rtl/wsp_wir_loader.sv
// wsp_wir_loader: Wrapper Serial Port initiator that loads one instruction into
// an IEEE 1500 WIR chain. It runs CaptureWR, WIR_LEN ShiftWR cycles and then
// UpdateWR, driving the WIR cell strobes and the serial input of the chain.
//
// Build option:
//   WSP_READBACK_EN - when defined, wir_so is sampled during ShiftWR and rd_data
//                     reports the WIR contents that were shifted out. When not
//                     defined, rd_data is tied to zero and wir_so is ignored;
//                     sequencing and timing are identical in both builds.
//
// Every output is registered. The output values for the next cycle are derived
// from the next state, so each strobe lines up exactly with its state.
module wsp_wir_loader #(
  parameter int WIR_LEN = 3
) (
  input  logic               WRCK,
  input  logic               WRST,
  input  logic               start,
  input  logic [WIR_LEN-1:0] instr,
  output logic               ready,
  output logic               done,
  output logic [WIR_LEN-1:0] rd_data,
  output logic               select_wir,
  output logic               wir_capture,
  output logic               wir_shift,
  output logic               wir_update,
  output logic               wir_si,
  input  logic               wir_so
);

  // The counter has to hold WIR_LEN itself, so it never wraps inside SHIFT.
  localparam int CNT_W = $clog2(WIR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SHIFT   = 3'd2,
    S_UPDATE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIR_LEN-1:0] r_sh_reg;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;
  logic               w_last_shift;

  logic w_ready_nxt;
  logic w_done_nxt;
  logic w_select_nxt;
  logic w_capture_nxt;
  logic w_shift_nxt;
  logic w_update_nxt;
  logic w_si_nxt;

  // A request is taken only from IDLE; anything arriving while busy is dropped.
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last_shift = (r_cnt == CNT_LAST);

  // State register: reset overrides everything, including a load in flight.
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one state per cycle except SHIFT, which lasts WIR_LEN cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state; at most one WIR strobe is ever active.
  always_comb begin
    w_ready_nxt   = (w_state_nxt == S_IDLE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_select_nxt  = (w_state_nxt == S_CAPTURE) ||
                    (w_state_nxt == S_SHIFT)   ||
                    (w_state_nxt == S_UPDATE);
    w_capture_nxt = (w_state_nxt == S_CAPTURE);
    w_shift_nxt   = (w_state_nxt == S_SHIFT);
    w_update_nxt  = (w_state_nxt == S_UPDATE);
    // The bit presented for the coming shift edge is the current LSB of the
    // shift register; the register advances on the same edge.
    w_si_nxt      = (w_state_nxt == S_SHIFT) ? r_sh_reg[0] : 1'b0;
  end

  // Registered outputs toward the controller and the WIR cells.
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      ready       <= 1'b1;
      done        <= 1'b0;
      select_wir  <= 1'b0;
      wir_capture <= 1'b0;
      wir_shift   <= 1'b0;
      wir_update  <= 1'b0;
      wir_si      <= 1'b0;
    end else begin
      ready       <= w_ready_nxt;
      done        <= w_done_nxt;
      select_wir  <= w_select_nxt;
      wir_capture <= w_capture_nxt;
      wir_shift   <= w_shift_nxt;
      wir_update  <= w_update_nxt;
      wir_si      <= w_si_nxt;
    end
  end

  // Instruction shift register and bit counter; instr is sampled only on acceptance.
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      r_sh_reg <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_sh_reg <= instr;
      end else if (w_state_nxt == S_SHIFT) begin
        r_sh_reg <= r_sh_reg >> 1;
      end

      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef WSP_READBACK_EN
  logic [WIR_LEN-1:0] r_rd_shift;
  logic [WIR_LEN-1:0] w_rd_shift_nxt;

  // Serial-in from the top: after WIR_LEN shifts the first bit out sits at bit 0.
  // Written this way so that WIR_LEN = 1 needs no special case.
  function automatic logic [WIR_LEN-1:0] f_shift_in(input logic so,
                                                   input logic [WIR_LEN-1:0] cur);
    logic [WIR_LEN-1:0] v;
    v            = cur >> 1;
    v[WIR_LEN-1] = so;
    return v;
  endfunction

  assign w_rd_shift_nxt = f_shift_in(wir_so, r_rd_shift);

  // Collect the chain's serial output while shifting and publish it when entering UPDATE.
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      r_rd_shift <= '0;
      rd_data    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_rd_shift <= w_rd_shift_nxt;
      if (w_state_nxt == S_UPDATE) begin
        rd_data <= w_rd_shift_nxt;
      end
    end
  end
`else
  // Readback is not built: the chain output is intentionally left unobserved.
  logic w_unused_so;
  assign w_unused_so = wir_so;
  assign rd_data     = '0;
`endif

endmodule
